// File: rtl/ir_command_sequencer.sv
// ir_command_sequencer: bus-queued IR command script player with manual override and done interrupt
module ir_command_sequencer #(
    parameter logic [7:0] BASE_ADDR = 8'h94,
    parameter logic [3:0] IDLE_CMD  = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       SEND_PACKET,
    input  logic       MODE,
    input  logic [3:0] MANUAL_CMD,
    output logic [3:0] COMMAND,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);
    localparam logic [7:0] CTRL_ADDR = BASE_ADDR + 8'd1;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, next_state;
    logic [7:0] mem [8];
    logic [7:0] head, status;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count, cur_cmd;
    logic [4:0] remaining;
    logic ovf, queue_wr, flush, full, empty, pop, push, tick, done;
    assign queue_wr = BUS_WE && BUS_ADDR == BASE_ADDR;
    assign flush = BUS_WE && BUS_ADDR == CTRL_ADDR && BUS_DATA[0];
    assign full = count == 4'd8;
    assign empty = count == 4'd0;
    assign head = mem[rd_ptr];
    assign pop = !MODE && state == LOAD && !flush;
    assign push = queue_wr && !flush && (!full || pop);
    assign tick = !MODE && state == RUN && SEND_PACKET && !flush;
    assign done = tick && remaining == 5'd1 && empty;
    assign status = {ovf, state != IDLE, full, empty, count};
    assign BUS_DATA = (!BUS_WE && BUS_ADDR == CTRL_ADDR) ? status : 8'hzz;
    assign COMMAND = MODE ? MANUAL_CMD : (state == RUN ? cur_cmd : IDLE_CMD);
    // queue storage; no reset needed since pointers and count gate every read
    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= BUS_DATA;
    // state register, pointers, entry countdown, overflow and interrupt flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count <= 4'd0;
            cur_cmd <= IDLE_CMD;
            remaining <= 5'd0;
            ovf <= 1'b0;
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
                cur_cmd <= head[3:0];
                remaining <= head[7:4] == 4'd0 ? 5'd16 : {1'b0, head[7:4]};
            end
            if (tick) remaining <= remaining - 5'd1;
            count <= count + {3'b0, push} - {3'b0, pop};
            if (queue_wr && full && !pop && !flush) ovf <= 1'b1;
            BUS_INTERRUPT_RAISE <= done | (BUS_INTERRUPT_RAISE & ~BUS_INTERRUPT_ACK);
            if (flush) begin
                wr_ptr <= 3'd0;
                rd_ptr <= 3'd0;
                count <= 4'd0;
                ovf <= 1'b0;
                remaining <= 5'd0;
            end
        end
    end
    // next state: flush forces idle, manual mode freezes, packets end entries only in RUN
    always_comb begin
        next_state = state;
        if (flush) next_state = IDLE;
        else if (!MODE)
            next_state = state == IDLE ? (empty ? IDLE : LOAD) :
                         state == LOAD ? RUN :
                         (SEND_PACKET && remaining == 5'd1) ? (empty ? IDLE : LOAD) : RUN;
    end
endmodule
